// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters. One operation is in
//   flight at a time. A request is accepted over a valid/ready handshake and its
//   operands are captured. The ALU result and zero flag are registered. They are
//   returned to the requester that was granted, over a second valid/ready handshake.
//
//   Build option: define ALU_ARB_RR_EN for round-robin tie breaking. When it is
//   not defined, port 0 always wins a tie and no last-grant pointer is built.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   req{0,1}_valid/ready           request handshake
//   req{0,1}_op/a/b                opcode and operands of the request
//   rsp{0,1}_valid/ready           response handshake
//   rsp{0,1}_data/zero             registered result and zero flag
//   alu_op, alu_a, alu_b           operand registers driven to the ALU
//   alu_out, alu_zero              ALU result and zero flag
//   busy                           high whenever the FSM is not in IDLE
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | arbitrate, accept one request and capture its operands
// EXEC  | operand registers drive the ALU, result registered at edge
// RESP  | result offered to the owner until rsp_ready
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_zero,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             owner;
  logic [OPW-1:0]   op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] result;
  logic             zero_r;

  logic grant;
  logic idle_ok;
  logic accept;
  logic rsp_done;

  // grant only selects a port; ready additionally needs that port to be valid
`ifdef ALU_ARB_RR_EN
  logic last_grant;

  always_comb begin
    grant = !req0_valid;
    if (req0_valid && req1_valid) grant = !last_grant;
  end

  // pointer moves only when a response completes, so an aborted transaction
  // does not change the arbitration order
  always_ff @(posedge clk) begin
    if (rst) last_grant <= 1'b1;
    else if (rsp_done) last_grant <= owner;
  end
`else
  always_comb begin
    grant = !req0_valid;
  end
`endif

  // rst gating keeps every handshake output low during the reset cycle,
  // even if the FSM is still in RESP before the reset edge
  assign idle_ok    = (state == IDLE) && !rst;
  assign req0_ready = idle_ok && req0_valid && !grant;
  assign req1_ready = idle_ok && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  assign rsp0_valid = (state == RESP) && !owner && !rst;
  assign rsp1_valid = (state == RESP) && owner && !rst;
  assign rsp_done   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  assign rsp0_data  = result;
  assign rsp1_data  = result;
  assign rsp0_zero  = zero_r;
  assign rsp1_zero  = zero_r;

  assign alu_op     = op_r;
  assign alu_a      = a_r;
  assign alu_b      = b_r;

  assign busy       = (state != IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= 1'b0;
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      result <= '0;
      zero_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner <= grant;
            op_r  <= grant ? req1_op : req0_op;
            a_r   <= grant ? req1_a  : req0_a;
            b_r   <= grant ? req1_b  : req0_b;
            state <= EXEC;
          end
        end
        EXEC: begin
          result <= alu_out;
          zero_r <= alu_zero;
          state  <= RESP;
        end
        RESP: begin
          if (rsp_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
